// File: rtl/pipelined_addsub_if.sv
// Handshake and data bundle for pipelined_addsub.
// master drives operands and out_ready; slave is the adder itself.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Segmented-carry add/subtract, one WIDTH/SEGS slice per pipeline stage.
// Ports: clk, rst (async, active high), io (slave): in_valid/in_ready,
// a, b, cin, op (0 add, 1 sub) in; out_valid/out_ready, sum, cout, ovf,
// zero out. All stages advance together when out is empty or consumed.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4
) (
    input logic               clk,
    input logic               rst,
    pipelined_addsub_if.slave io
);
    localparam int W = WIDTH / SEGS;

    // Per-stage state: operands (b already conditioned for subtract),
    // partial sum, carry out of the finished segment.
    logic [SEGS-1:0]  vld_q, vld_d;
    logic [WIDTH-1:0] a_q  [SEGS];
    logic [WIDTH-1:0] a_d  [SEGS];
    logic [WIDTH-1:0] bx_q [SEGS];
    logic [WIDTH-1:0] bx_d [SEGS];
    logic [WIDTH-1:0] s_q  [SEGS];
    logic [WIDTH-1:0] s_d  [SEGS];
    logic [SEGS-1:0]  cy_q, cy_d;
    logic             ovf_q, ovf_d;
    logic             adv;

    assign adv = !vld_q[SEGS-1] || io.out_ready;

    always_comb begin : next_state
        logic [WIDTH-1:0] sa;
        logic [WIDTH-1:0] sb;
        logic [WIDTH-1:0] ss;
        logic             sc;
        logic             p;
        logic             g;
        logic             cmsb;
        vld_d = vld_q;
        a_d   = a_q;
        bx_d  = bx_q;
        s_d   = s_q;
        cy_d  = cy_q;
        ovf_d = ovf_q;
        sa    = '0;
        sb    = '0;
        ss    = '0;
        sc    = 1'b0;
        p     = 1'b0;
        g     = 1'b0;
        cmsb  = 1'b0;
        if (adv) begin
            for (int k = 0; k < SEGS; k++) begin
                if (k == 0) begin
                    // Subtract is a + ~b + !cin; capture op/cin here.
                    vld_d[0] = io.in_valid;
                    sa = io.a;
                    sb = io.op ? ~io.b : io.b;
                    sc = io.op ? !io.cin : io.cin;
                    ss = '0;
                end else begin
                    vld_d[k] = vld_q[k-1];
                    sa = a_q[k-1];
                    sb = bx_q[k-1];
                    sc = cy_q[k-1];
                    ss = s_q[k-1];
                end
                for (int i = 0; i < W; i++) begin
                    p    = sa[k*W+i] ^ sb[k*W+i];
                    g    = sa[k*W+i] & sb[k*W+i];
                    cmsb = sc;
                    ss[k*W+i] = p ^ sc;
                    sc   = g | (p & sc);
                end
                a_d[k]  = sa;
                bx_d[k] = sb;
                s_d[k]  = ss;
                cy_d[k] = sc;
            end
            // Last bit processed is the MSB, so cmsb is its carry-in.
            ovf_d = cmsb ^ sc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < SEGS; k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            bx_q  <= bx_d;
            s_q   <= s_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
        end
    end

    assign io.in_ready  = adv;
    assign io.out_valid = vld_q[SEGS-1];
    assign io.sum       = s_q[SEGS-1];
    assign io.cout      = cy_q[SEGS-1];
    assign io.ovf       = ovf_q;
    // Gated by valid so a cleared sum never reads as zero.
    assign io.zero      = vld_q[SEGS-1] && (s_q[SEGS-1] == '0);
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and random checks for pipelined_addsub.
// Main build 32/4, plus 8/2 and 16/1 builds in the random phase.
module tb_pipelined_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(32)) io ();
    pipelined_addsub_if #(.WIDTH(8))  io8 ();
    pipelined_addsub_if #(.WIDTH(16)) io16 ();

    pipelined_addsub #(.WIDTH(32), .SEGS(4)) dut (
        .clk(clk), .rst(rst), .io(io)
    );
    pipelined_addsub #(.WIDTH(8), .SEGS(2)) dut8 (
        .clk(clk), .rst(rst), .io(io8)
    );
    pipelined_addsub #(.WIDTH(16), .SEGS(1)) dut16 (
        .clk(clk), .rst(rst), .io(io16)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic v, logic [31:0] a, logic [31:0] b,
                         logic ci, logic o, logic rdy);
        @(negedge clk);
        io.in_valid  = v;
        io.a         = a;
        io.b         = b;
        io.cin       = ci;
        io.op        = o;
        io.out_ready = rdy;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    // Reference: {zero, ovf, cout, sum} for a w-bit operation.
    function automatic logic [34:0] model(int w, logic [31:0] a,
                                          logic [31:0] b, logic ci,
                                          logic o);
        logic [63:0] mask;
        logic [63:0] aa;
        logic [63:0] bb;
        logic [63:0] full;
        logic [31:0] s;
        logic        cy;
        logic        ov;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'b0, a} & mask;
        bb   = (o ? ~{32'b0, b} : {32'b0, b}) & mask;
        full = aa + bb + {63'b0, (o ? !ci : ci)};
        s    = full[31:0] & mask[31:0];
        cy   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {(s == 32'h0), ov, cy, s};
    endfunction

    function automatic logic [31:0] st_a(int i);
        return 32'h8000_0000 + 32'h1357_9BDF * i;
    endfunction

    function automatic logic [31:0] st_b(int i);
        return 32'h0F0F_0F0F * (i + 1);
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [34:0] frz;
        logic [34:0] q32[$];
        logic [34:0] q8[$];
        logic [34:0] q16[$];
        logic [31:0] r;
        int          sent;
        int          got;
        int          stall;
        int          cnt;
        logic        seen;
        logic        act;

        io.in_valid = 0; io.a = 0; io.b = 0; io.cin = 0; io.op = 0;
        io.out_ready = 1;
        io8.in_valid = 0; io8.a = 0; io8.b = 0; io8.cin = 0;
        io8.op = 0; io8.out_ready = 1;
        io16.in_valid = 0; io16.a = 0; io16.b = 0; io16.cin = 0;
        io16.op = 0; io16.out_ready = 1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", io.out_valid, 0);
        check("rst_zero", io.zero, 0);
        check("rst_sum", io.sum, 0);
        check("rst_cout", io.cout, 0);
        check("rst_ovf", io.ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", io.in_ready, 1);

        // Carry across every segment
        drive(1, 32'hFFFF_FFFF, 32'h1, 0, 0, 1);
        idle(); idle(); idle();
        check("lat_not_early", io.out_valid, 0);
        idle();
        check("carry_valid", io.out_valid, 1);
        check("carry_res", {io.zero, io.ovf, io.cout, io.sum},
              {1'b1, 1'b0, 1'b1, 32'h0});

        // Add overflow then subtract overflow, back to back
        drive(1, 32'h7FFF_FFFF, 32'h1, 0, 0, 1);
        drive(1, 32'h8000_0000, 32'h1, 0, 1, 1);
        idle(); idle(); idle();
        check("ovf_add", {io.out_valid, io.zero, io.ovf, io.cout, io.sum},
              {1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0000});
        idle();
        check("ovf_sub", {io.out_valid, io.zero, io.ovf, io.cout, io.sum},
              {1'b1, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF});

        // Borrow
        drive(1, 32'h5, 32'h7, 0, 1, 1);
        idle(); idle(); idle(); idle();
        check("borrow", {io.out_valid, io.zero, io.ovf, io.cout, io.sum},
              {1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
        repeat (4) idle();

        // Stream of 8 with a 3-cycle stall at the first result
        sent = 0; got = 0; stall = 0; seen = 0; frz = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!seen && io.out_valid) begin
                seen  = 1;
                stall = 3;
            end
            io.in_valid  = sent < 8;
            io.a         = st_a(sent);
            io.b         = st_b(sent);
            io.op        = sent[0];
            io.cin       = sent[1];
            io.out_ready = stall == 0;
            #1;
            if (stall == 3) begin
                frz = {io.zero, io.ovf, io.cout, io.sum};
            end else if (stall > 0) begin
                check("stall_frozen", {io.zero, io.ovf, io.cout, io.sum}, frz);
            end
            if (stall > 0) begin
                check("stall_in_ready", io.in_ready, 0);
                check("stall_valid", io.out_valid, 1);
            end
            if (io.out_valid && io.out_ready) begin
                check("stream_res", {io.zero, io.ovf, io.cout, io.sum},
                      got < 8 ? model(32, st_a(got), st_b(got),
                                      got[1], got[0]) : 35'bx);
                got++;
            end
            if (io.in_valid && io.in_ready) sent++;
            if (stall > 0) stall--;
        end
        check("stream_count", got, 8);

        // Reset with three transactions in flight
        drive(1, 32'h1, 32'h1, 0, 0, 0);
        drive(1, 32'h2, 32'h2, 0, 0, 0);
        drive(1, 32'h3, 32'h3, 0, 0, 0);
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        check("pre_rst_out", {io.out_valid, io.sum}, {1'b1, 32'h2});
        rst = 1'b1;
        #1;
        check("rst_async_valid", io.out_valid, 0);
        check("rst_async_sum", io.sum, 0);
        check("rst_async_zero", io.zero, 0);
        @(negedge clk);
        rst = 1'b0;
        io.out_ready = 1;
        #1;
        check("rst2_ready", io.in_ready, 1);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            idle();
            if (io.out_valid) cnt++;
        end
        check("rst_flushed", cnt, 0);
        drive(1, 32'h1234_5678, 32'h1111_1111, 1, 0, 1);
        idle(); idle(); idle();
        check("rst_new_early", io.out_valid, 0);
        idle();
        check("rst_new_res", {io.out_valid, io.cout, io.sum},
              {1'b1, 1'b0, 32'h2345_678A});
        repeat (4) idle();

        // Random traffic on all three builds
        for (int c = 0; c < 10012; c++) begin
            @(negedge clk);
            act = c < 10000;
            io.in_valid  = act && ($urandom_range(0, 3) != 0);
            io.a         = rnd32();
            io.b         = rnd32();
            io.cin       = $urandom_range(0, 1) != 0;
            io.op        = $urandom_range(0, 1) != 0;
            io.out_ready = !act || ($urandom_range(0, 3) != 0);
            io8.in_valid  = act && ($urandom_range(0, 3) != 0);
            r = rnd32();
            io8.a         = r[7:0];
            r = rnd32();
            io8.b         = r[7:0];
            io8.cin       = $urandom_range(0, 1) != 0;
            io8.op        = $urandom_range(0, 1) != 0;
            io8.out_ready = !act || ($urandom_range(0, 3) != 0);
            io16.in_valid  = act && ($urandom_range(0, 3) != 0);
            r = rnd32();
            io16.a         = r[15:0];
            r = rnd32();
            io16.b         = r[15:0];
            io16.cin       = $urandom_range(0, 1) != 0;
            io16.op        = $urandom_range(0, 1) != 0;
            io16.out_ready = !act || ($urandom_range(0, 3) != 0);
            #1;
            if (io.out_valid && io.out_ready)
                check("rnd32", {io.zero, io.ovf, io.cout, io.sum},
                      q32.size() > 0 ? q32.pop_front() : 35'bx);
            if (io.in_valid && io.in_ready)
                q32.push_back(model(32, io.a, io.b, io.cin, io.op));
            if (io8.out_valid && io8.out_ready)
                check("rnd8", {io8.zero, io8.ovf, io8.cout, 24'b0, io8.sum},
                      q8.size() > 0 ? q8.pop_front() : 35'bx);
            if (io8.in_valid && io8.in_ready)
                q8.push_back(model(8, {24'b0, io8.a}, {24'b0, io8.b},
                                   io8.cin, io8.op));
            if (io16.out_valid && io16.out_ready)
                check("rnd16", {io16.zero, io16.ovf, io16.cout, 16'b0, io16.sum},
                      q16.size() > 0 ? q16.pop_front() : 35'bx);
            if (io16.in_valid && io16.in_ready)
                q16.push_back(model(16, {16'b0, io16.a}, {16'b0, io16.b},
                                    io16.cin, io16.op));
        end
        check("rnd32_drain", q32.size(), 0);
        check("rnd8_drain", q8.size(), 0);
        check("rnd16_drain", q16.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 The block SHALL have parameter SEGS, default 4: number of carry-chain segments and pipeline stages; legal only when WIDTH % SEGS == 0 and SEGS >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in for add, borrow-in for subtract.
REQ-010 The block SHALL have port op, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result port holds a valid result.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-013 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-014 The block SHALL have port cout, output, 1 bit: carry-out of the MSB.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-016 The block SHALL have port zero, output, 1 bit: asserted when sum == 0.

Function
REQ-017 Add (op=0) SHALL compute {cout,sum} = a + b + cin.
REQ-018 Subtract (op=1) SHALL compute {cout,sum} = a + ~b + !cin, which equals a - b - cin; cout=1 SHALL mean no borrow.
REQ-019 Stage k (k = 0..SEGS-1) SHALL compute segment k, bits [(k+1)*W/SEGS-1 : k*W/SEGS], as a ripple generate/propagate chain using the carry registered from stage k-1.
REQ-020 Operands not yet consumed and finished sum bits SHALL travel in pipeline registers alongside the data.
REQ-021 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-022 zero SHALL be derived from the final registered sum.
REQ-023 Pipeline advance SHALL be defined as adv = !out_valid || out_ready, and all stages SHALL shift together only when adv=1.
REQ-024 in_ready SHALL equal adv, combinationally; an operand set SHALL be accepted on a cycle where in_valid && in_ready.
REQ-025 A cycle where adv=1 and no operand set is accepted SHALL insert a bubble, and bubbles SHALL NOT be compacted.
REQ-026 Latency SHALL be exactly SEGS cycles from acceptance to out_valid when there is no stall; throughput SHALL be 1 result per cycle.
REQ-027 While out_valid && !out_ready, sum, cout, ovf, zero and out_valid SHALL hold stable and no stage SHALL update.
REQ-028 Results SHALL emerge in acceptance order with no loss or duplication under arbitrary in_valid/out_ready patterns.
REQ-029 Each accepted transaction's op and cin SHALL be captured at acceptance, so a mix of add and subtract in consecutive cycles is legal.
REQ-030 With SEGS=1, the block SHALL be a single registered stage with latency 1.

Reset
REQ-031 rst=1 SHALL asynchronously clear all stage valid bits, out_valid, sum, cout, ovf and zero to 0.
REQ-032 While rst=1, zero SHALL read 0, not 1.
REQ-033 In-flight transactions SHALL be discarded on reset, and no result SHALL be produced for them.
REQ-034 in_ready SHALL be 1 from the first cycle after reset deassertion.
REQ-035 Data registers other than those listed in REQ-031 MAY be left unreset.

Verification (WIDTH=32, SEGS=4)
REQ-036 The bench SHALL apply a=0xFFFFFFFF, b=0x00000001, cin=0, op=0 -> 4 cycles later sum=0, cout=1, ovf=0, zero=1 (carry crossing all segments).
REQ-037 The bench SHALL apply a=0x7FFFFFFF, b=1, op=0, then a=0x80000000, b=1, cin=0, op=1 back-to-back -> sum=0x80000000 with ovf=1, then sum=0x7FFFFFFF with ovf=1 and cout=1, on consecutive cycles.
REQ-038 The bench SHALL apply a=5, b=7, op=1, cin=0 -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0.
REQ-039 The bench SHALL stream 8 transactions with out_ready held 0 for 3 cycles after the first result -> outputs stay frozen, in_ready=0 during the stall, and all 8 results arrive in order with no loss.
REQ-040 The bench SHALL assert rst for 1 cycle with 3 transactions in flight -> out_valid=0 immediately, none of the 3 results appear, and a new transaction completes 4 cycles after acceptance.
REQ-041 The bench SHALL run 10k random operand, op, cin, in_valid and out_ready values against a reference model, plus WIDTH=8/SEGS=2 and WIDTH=16/SEGS=1 builds -> zero mismatches.
